// File: rtl/cla_pipe_adder_if.sv
// Handshake and data bundle for the pipelined CLA adder/subtractor.
// The producer drives operands and out_ready; the adder drives in_ready and the result side.
interface cla_pipe_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, op, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, op, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, neg
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one WIDTH/STAGES chunk per stage,
// operand skew ahead of the active chunk and result deskew behind it.
module cla_pipe_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input logic             clk,
  input logic             rst,
  cla_pipe_adder_if.slave bus
);
  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned NGRP  = (CHUNK + 3) / 4;

  // Bit carries of one chunk: prefix G/P inside each 4-bit group, group G/P between groups.
  function automatic logic [CHUNK:0] cla_carries(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] g;
    logic [CHUNK:0]   c;
    logic             run_g;
    logic             run_p;
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = ci;
    for (int unsigned grp = 0; grp < NGRP; grp++) begin
      run_g = 1'b0;
      run_p = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
        if (4 * grp + i < CHUNK) begin
          run_g = g[4*grp+i] | (p[4*grp+i] & run_g);
          run_p = run_p & p[4*grp+i];
          c[4*grp+i+1] = run_g | (run_p & c[4*grp]);
        end
      end
    end
    return c;
  endfunction

  function automatic logic [WIDTH-1:0] place_chunk(input logic [WIDTH-1:0] base,
                                                   input logic [CHUNK-1:0] chunk,
                                                   input int unsigned      idx);
    logic [WIDTH-1:0] r;
    r = base;
    r[idx*CHUNK +: CHUNK] = chunk;
    return r;
  endfunction

  logic              en;
  logic              in_ready;
  logic [WIDTH-1:0]  b_in;
  logic              c_in;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  s_q   [STAGES];
  logic [WIDTH-1:0]  s_d   [STAGES];
  logic [CHUNK:0]    car   [STAGES];
  logic [CHUNK-1:0]  ssum  [STAGES];

  logic              out_valid_q;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;

  assign en       = !out_valid_q || bus.out_ready;
  assign in_ready = en && !rst;

  always_comb begin
    b_in = bus.op[0] ? ~bus.b : bus.b;
    case (bus.op)
      2'b00:   c_in = 1'b0;
      2'b01:   c_in = 1'b1;
      default: c_in = bus.cin;
    endcase
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign car[k]  = cla_carries(a_q[k][k*CHUNK +: CHUNK], b_q[k][k*CHUNK +: CHUNK], c_q[k]);
    assign ssum[k] = a_q[k][k*CHUNK +: CHUNK] ^ b_q[k][k*CHUNK +: CHUNK] ^ car[k][CHUNK-1:0];
    if (k == 0) begin : g_first
      assign s_d[k] = '0;
    end else begin : g_next
      assign s_d[k] = place_chunk(s_q[k-1], ssum[k-1], k - 1);
    end
  end

  // The last stage's carry vector still holds the carry into bit WIDTH-1 for overflow.
  always_comb begin
    sum_d  = place_chunk(s_q[STAGES-1], ssum[STAGES-1], STAGES - 1);
    cout_d = car[STAGES-1][CHUNK];
    ovf_d  = car[STAGES-1][CHUNK] ^ car[STAGES-1][CHUNK-1];
    zero_d = (sum_d == '0);
    neg_d  = sum_d[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      c_q         <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else if (en) begin
      vld_q[0] <= bus.in_valid && in_ready;
      a_q[0]   <= bus.a;
      b_q[0]   <= b_in;
      c_q[0]   <= c_in;
      s_q[0]   <= s_d[0];
      for (int unsigned k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        c_q[k]   <= car[k-1][CHUNK];
        s_q[k]   <= s_d[k];
      end
      out_valid_q <= vld_q[STAGES-1];
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder at STAGES 4, 1, 2 and 8 sharing one stimulus stream;
// each instance keeps its own in-order expected-result queue.
module tb_cla_pipe_adder;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        cin;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {valid, cout, ovf, zero, neg, sum} from plain wide arithmetic and the sign rule.
  function automatic logic [36:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y, input logic ci);
    logic [31:0] yy;
    logic        c0;
    logic [32:0] full;
    logic        ov;
    yy   = o[0] ? ~y : y;
    c0   = (o == 2'b01) ? 1'b1 : (o[1] ? ci : 1'b0);
    full = {1'b0, x} + {1'b0, yy} + {32'd0, c0};
    ov   = (x[31] == yy[31]) && (full[31] != x[31]);
    return {1'b1, full[32], ov, (full[31:0] == 32'd0), full[31], full[31:0]};
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int unsigned S = (i == 0) ? 4 : (i == 1) ? 1 : (i == 2) ? 2 : 8;

    cla_pipe_adder_if #(.WIDTH(32)) bus ();

    assign bus.in_valid  = in_valid;
    assign bus.a         = a;
    assign bus.b         = b;
    assign bus.op        = op;
    assign bus.cin       = cin;
    assign bus.out_ready = out_ready;

    cla_pipe_adder #(.WIDTH(32), .STAGES(S)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    logic [36:0] obs;
    assign obs = {bus.out_valid, bus.cout, bus.ovf, bus.zero, bus.neg, bus.sum};

    logic [36:0] exp_q[$];
    int n_out   = 0;
    int pending = 0;
    int run     = 0;
    int best    = 0;

    initial begin
      logic [36:0] held;
      logic [36:0] expv;
      logic        hold_prev;
      logic        rst_prev;
      held      = '0;
      hold_prev = 1'b0;
      rst_prev  = 1'b0;
      forever begin
        @(negedge clk);
        if (rst_prev) check_eq($sformatf("s%0d_rst_flush", S), 64'(obs[36]), 64'd0);
        if (hold_prev) check_eq($sformatf("s%0d_hold", S), 64'(obs), 64'(held));
        if (rst) begin
          exp_q.delete();
          hold_prev = 1'b0;
          run       = 0;
        end else begin
          if (obs[36] && !out_ready)
            check_eq($sformatf("s%0d_stall_in_ready", S), 64'(bus.in_ready), 64'd0);
          if (obs[36] && out_ready) begin
            run++;
            if (run > best) best = run;
            if (exp_q.size() == 0) begin
              check_eq($sformatf("s%0d_unexpected_out", S), 64'(obs[36]), 64'd0);
            end else begin
              expv = exp_q.pop_front();
              check_eq($sformatf("s%0d_result", S), 64'(obs), 64'(expv));
              n_out++;
            end
          end else begin
            run = 0;
          end
          if (in_valid && bus.in_ready) exp_q.push_back(ref_model(op, a, b, cin));
          hold_prev = obs[36] && !out_ready;
          held      = obs;
        end
        pending  = exp_q.size();
        rst_prev = rst;
      end
    end
  end

  task automatic drive(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic ci);
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    cin      = ci;
    @(posedge clk);
    #1;
  endtask

  // One isolated operation on the STAGES=4 instance with an exact latency check.
  task automatic directed(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic ci, input logic [31:0] es,
                          input logic [3:0] ef);
    logic [36:0] expv;
    expv = {1'b1, ef, es};
    @(posedge clk);
    #1;
    check_eq({tag, "_ready"}, 64'(g_dut[0].bus.in_ready), 64'd1);
    drive(o, x, y, ci);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_eq({tag, "_early"}, 64'(g_dut[0].obs[36]), 64'd0);
    end
    @(posedge clk);
    #1;
    check_eq(tag, 64'(g_dut[0].obs), 64'(expv));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = 2'b00;
    cin       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_state", 64'(g_dut[0].obs), 64'd0);
    check_eq("reset_in_ready", 64'(g_dut[0].bus.in_ready), 64'd0);
    rst = 1'b0;

    directed("add_wrap",       2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1010);
    directed("sub_ovf",        2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b1100);
    directed("sub_borrow",     2'b01, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 4'b0001);
    directed("adc_chunk",      2'b10, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0001_0000, 4'b0000);
    directed("sbb_cin0",       2'b11, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0001, 4'b1000);
    directed("add_ovf",        2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0101);
    directed("sbb_zero",       2'b11, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 4'b0001);
    directed("adc_full",       2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 4'b1001);
    directed("add_ignore_cin", 2'b00, 32'h0000_0005, 32'h0000_0006, 1'b1, 32'h0000_000B, 4'b0000);
    directed("sub_ignore_cin", 2'b01, 32'h0000_0009, 32'h0000_0009, 1'b0, 32'h0000_0000, 4'b1010);

    // Back-to-back stream across all four modes.
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++)
      drive(2'(i % 4), $urandom, $urandom, 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_eq("stream_run", 64'(g_dut[0].best), 64'd16);

    // Fill the 4-stage pipe, then stall the consumer for 3 cycles.
    drive(2'b00, 32'h1111_1111, 32'h2222_2222, 1'b0);
    drive(2'b01, 32'h0000_0010, 32'h0000_0020, 1'b0);
    drive(2'b10, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    drive(2'b11, 32'h0000_0100, 32'h0000_00FF, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check_eq("bp_first", 64'(g_dut[0].obs), 64'({1'b1, 4'b0000, 32'h3333_3333}));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_eq("bp_in_ready", 64'(g_dut[0].bus.in_ready), 64'd0);
      check_eq("bp_hold", 64'(g_dut[0].obs), 64'({1'b1, 4'b0000, 32'h3333_3333}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_second", 64'(g_dut[0].obs), 64'({1'b1, 4'b0001, 32'hFFFF_FFF0}));
    @(posedge clk);
    #1;
    check_eq("bp_third", 64'(g_dut[0].obs), 64'({1'b1, 4'b0101, 32'h8000_0000}));
    @(posedge clk);
    #1;
    check_eq("bp_fourth", 64'(g_dut[0].obs), 64'({1'b1, 4'b1000, 32'h0000_0001}));
    @(posedge clk);
    #1;
    check_eq("bp_drained", 64'(g_dut[0].obs[36]), 64'd0);
    repeat (8) @(posedge clk);
    #1;

    // Three operations in flight, then a one-cycle reset.
    drive(2'b00, 32'h0000_0001, 32'h0000_0001, 1'b0);
    drive(2'b01, 32'h0000_0007, 32'h0000_0002, 1'b0);
    drive(2'b10, 32'h0000_0003, 32'h0000_0004, 1'b1);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(g_dut[0].obs[36]), 64'd0);
    check_eq("rst_in_ready", 64'(g_dut[0].bus.in_ready), 64'd0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      check_eq("no_stale", 64'(g_dut[0].obs[36]), 64'd0);
    end
    directed("post_rst_add", 2'b00, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 4'b0000);

    repeat (12) @(posedge clk);
    #1;
    check_eq("s4_drain", 64'(g_dut[0].pending), 64'd0);
    check_eq("s1_drain", 64'(g_dut[1].pending), 64'd0);
    check_eq("s2_drain", 64'(g_dut[2].pending), 64'd0);
    check_eq("s8_drain", 64'(g_dut[3].pending), 64'd0);
    check_eq("s4_count", 64'(g_dut[0].n_out), 64'd31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshaking. Splits a WIDTH-bit operation into STAGES equal chunks, one chunk per pipeline stage, with the inter-chunk carry registered between stages. Each chunk resolves its carries with 4-bit CLA groups. Sits in the ALU datapath as the high-frequency replacement for the purely combinational CLA adder, and adds subtract/carry-in modes, status flags and backpressure.

## Interface
- WIDTH, 32: operand and result width. Must be a multiple of STAGES.
- STAGES, 4: number of pipeline stages, which is also the latency. 1 ≤ STAGES ≤ WIDTH; CHUNK = WIDTH/STAGES.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand presented.
- in_ready  out  1  block accepts an operand this cycle.
- a, b  in  WIDTH  operands (two's complement for flag purposes).
- op  in  2  mode: 00 ADD a+b; 01 SUB a+~b+1; 10 ADC a+b+cin; 11 SBB a+~b+cin.
- cin  in  1  carry-in. Used only by ADC/SBB; for SBB, cin=1 means no borrow.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB. For SUB/SBB, 1 means no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  sum == 0.
- neg  out  1  sum[WIDTH-1].

## Operation
- Global advance enable: en = !out_valid || out_ready. in_ready = en && !rst.
- A transfer occurs when in_valid && in_ready, or when out_valid && out_ready.
- On en, every stage register loads from its predecessor, and the stage-0 valid bit loads (in_valid && in_ready). When en=0, all registers hold.
- Bubbles are not collapsed: a stall freezes the whole pipe.
- Stage k (0..STAGES-1):
  - Computes sum chunk k from the skewed a/b chunk k (b inverted for op[0]=1) and carry c_k.
  - c_0 = 1 for SUB, cin for ADC/SBB, 0 for ADD.
  - c_{k+1} is registered alongside the data.
- Skew and deskew:
  - Operand chunks above k are delayed through skew registers.
  - Completed lower sum chunks are carried forward through deskew registers.
  - All chunks of one operation therefore leave together.
- Within a chunk, carries use generate/propagate in 4-bit groups with group P/G lookahead. A CHUNK below 4 uses a ripple of lookahead terms.
- Flags are computed in the final stage from the carry into and out of bit WIDTH-1, registered with sum.
- Results emerge strictly in acceptance order; none is dropped or duplicated.
- STAGES=1: a single registered CLA adder with latency 1.

## Timing
- Reset (synchronous):
  - out_valid=0; sum, cout, ovf, zero, neg = 0.
  - All stage valid bits and data registers are 0.
  - in_ready=0 while rst is high.
- Latency: an operand accepted at edge t appears with out_valid=1 after edge t+STAGES, provided no stall intervenes. Each stall cycle adds one cycle.
- Throughput: one operation per cycle while out_ready=1.
- Backpressure: if out_valid=1 and out_ready=0, then in_ready=0. sum and all flags stay stable until the cycle out_ready=1.
- Simultaneous output and input transfer in the same cycle is legal, and the pipe advances.
- Reset mid-operation: all in-flight operations are discarded. out_valid=0 from the edge where rst is sampled high. No stale result is ever presented after reset.
- out_valid, sum and the flags are registered outputs. in_ready is combinational from out_valid, out_ready and rst only; there is no path from in_valid or the data inputs.

## Test plan
- ADD 0xFFFFFFFF+0x00000001 (WIDTH=32, STAGES=4): after 4 cycles, sum=0x00000000, cout=1, zero=1, ovf=0, neg=0.
- SUB 0x80000000−0x00000001: sum=0x7FFFFFFF, cout=1, ovf=1, neg=0. SUB 0x00000000−0x00000001: sum=0xFFFFFFFF, cout=0, neg=1, ovf=0.
- Carry across chunk boundaries: ADC 0x0000FFFF+0x00000000 with cin=1 gives sum=0x00010000, cout=0. SBB 5−3 with cin=0 gives sum=1, cout=1.
- Streaming: 16 back-to-back random operations with out_ready=1. Results appear on 16 consecutive cycles, in order, and match a reference model across all four modes. Repeat with STAGES ∈ {1, 2, 8}.
- Backpressure: fill the pipe, then hold out_ready=0 for 3 cycles. in_ready=0 throughout, and sum and the flags are unchanged. After release, all results emerge in order with no loss or duplication.
- Reset mid-flight: 3 operations in flight, rst high for 1 cycle. out_valid=0 on the next cycle, and no pre-reset result ever appears. The first post-reset operation has latency STAGES.
